nor_reduce_seq: RTL and testbench
=================================

NOR_REDUCE_SEQ -- requirements
Module: nor_reduce_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width in bits (>=1).
REQ-002 SHALL provide parameter CHUNK, default 8, bits examined per scan cycle (1..WIDTH).
REQ-003 SHALL derive NCHUNK = ceil(WIDTH/CHUNK) and IW = max(1, clog2(WIDTH)).
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 CLK  input  1  clock, all state on rising edge.
REQ-006 RST  input  1  asynchronous active-high reset.
REQ-007 A  input  WIDTH  operand, sampled only on START acceptance.
REQ-008 START  input  1  request; accepted when state is IDLE or DONE.
REQ-009 BUSY  output  1  high while in SCAN.
REQ-010 DONE  output  1  one-cycle pulse, result valid.
REQ-011 Y  output  1  NOR of all operand bits (1 iff operand == 0).
REQ-012 IDX  output  IW  index of lowest set operand bit; 0 when Y=1.

Function
REQ-013 SHALL implement states IDLE, SCAN, DONE; BUSY = (state==SCAN), DONE = (state==DONE), both decoded from state only.
REQ-014 IDLE: START=1 -> capture A into operand register, chunk counter k=0, next SCAN; else stay IDLE.
REQ-015 SCAN, cycle k: SHALL examine operand bits [k*CHUNK +: CHUNK]; bits at positions >= WIDTH treated as 0.
REQ-016 SCAN, any examined bit set: SHALL load Y=0, IDX = k*CHUNK + lowest set position within the chunk, next DONE (early termination).
REQ-017 SCAN, no bit set and k < NCHUNK-1: SHALL increment k, stay SCAN.
REQ-018 SCAN, no bit set and k == NCHUNK-1: SHALL load Y=1, IDX=0, next DONE.
REQ-019 DONE: START=1 -> capture A, k=0, next SCAN (back-to-back); else next IDLE.
REQ-020 START while in SCAN SHALL be ignored; operand register, k, Y, IDX unaffected.
REQ-021 Y and IDX SHALL change only on the edge leaving SCAN and SHALL hold through IDLE and subsequent SCAN until the next result loads.
REQ-022 Latency: START accepted at edge of cycle 0, result found in chunk k -> DONE=1 in cycle k+2; worst case NCHUNK+1.
REQ-023 Throughput with back-to-back START: one result per (k+2) cycles, no idle bubble beyond the DONE cycle.
REQ-024 Chunk counter SHALL be sized clog2(NCHUNK) (min 1 bit) and never exceed NCHUNK-1; WIDTH not a multiple of CHUNK SHALL be supported (partial last chunk).
REQ-025 CHUNK == WIDTH SHALL give a single SCAN cycle (DONE in cycle 2 for all operands).
REQ-026 Outputs SHALL be registered or decoded from registered state; no combinational path from A or START to any output.

Reset
REQ-027 RST=1 SHALL immediately (asynchronously) force state=IDLE, k=0, operand register=0, BUSY=0, DONE=0, Y=1, IDX=0.
REQ-028 RST asserted mid-SCAN SHALL abort the operation with no DONE pulse; after release, block waits in IDLE for START.
REQ-029 START coincident with the first edge after RST release SHALL be accepted normally.

Verification
REQ-030 WIDTH=32, CHUNK=8, A=0x0000_0000, START cycle 0 -> BUSY cycles 1-4, DONE=1 cycle 5, Y=1, IDX=0.
REQ-031 WIDTH=32, CHUNK=8, A=0x0000_0100 -> DONE cycle 3, Y=0, IDX=8; A=0x8000_0001 -> DONE cycle 2, Y=0, IDX=0.
REQ-032 WIDTH=10, CHUNK=4, A=0x200 -> partial chunk 2, DONE cycle 4, Y=0, IDX=9.
REQ-033 START pulsed in SCAN with different A -> ignored, result from first A; START held in DONE cycle -> new SCAN next cycle, second DONE at expected cycle.
REQ-034 RST asserted cycle 2 of a 4-chunk zero scan -> BUSY=0, DONE=0, Y=1, IDX=0 immediately, no DONE pulse afterwards.
REQ-035 Randomised A over 10k ops vs reference model (Y = ~|A, IDX = lowest set bit) for (WIDTH,CHUNK) in {(32,8),(10,4),(7,7),(1,1)}, with latency checked per REQ-022.

Source files
------------

// File: rtl/nor_reduce_seq.sv
// Multi-cycle NOR reduction: scans the captured operand CHUNK bits per cycle,
// reporting Y = (operand == 0) and the index of the lowest set bit.
module nor_reduce_seq #(
    parameter int WIDTH  = 32,
    parameter int CHUNK  = 8,
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK,
    localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             y,
    output logic [IW-1:0]    idx
);

    localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CW = (CHUNK > 1) ? $clog2(CHUNK) : 1;
    localparam int PW = NCHUNK * CHUNK;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] op_reg;
    logic [KW-1:0]    k_reg;
    logic             y_reg;
    logic [IW-1:0]    idx_reg;

    logic [PW-1:0]    padded;
    logic [CHUNK-1:0] chunk_arr [NCHUNK];
    logic [CHUNK-1:0] chunk_sel;
    logic [CW-1:0]    pos;
    logic             hit;
    logic             k_last;
    logic [IW-1:0]    hit_idx;

    // Positions beyond WIDTH in the last chunk read as zero.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_pad
            if (gi < WIDTH) begin : g_bit
                assign padded[gi] = op_reg[gi];
            end else begin : g_zero
                assign padded[gi] = 1'b0;
            end
        end
        for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign chunk_arr[gi] = padded[gi*CHUNK +: CHUNK];
        end
    endgenerate

    always_comb begin
        chunk_sel = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (k_reg == KW'(i)) begin
                chunk_sel = chunk_arr[i];
            end
        end
    end

    // Descending scan so the lowest set position wins.
    always_comb begin
        pos = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (chunk_sel[i]) begin
                pos = CW'(i);
            end
        end
    end

    assign hit     = |chunk_sel;
    assign k_last  = (k_reg == KW'(NCHUNK - 1));
    assign hit_idx = IW'(32'(k_reg) * 32'(CHUNK) + 32'(pos));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            op_reg    <= '0;
            k_reg     <= '0;
            y_reg     <= 1'b1;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_reg    <= a;
                        k_reg     <= '0;
                        state_reg <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (hit) begin
                        y_reg     <= 1'b0;
                        idx_reg   <= hit_idx;
                        state_reg <= ST_DONE;
                    end else if (k_last) begin
                        y_reg     <= 1'b1;
                        idx_reg   <= '0;
                        state_reg <= ST_DONE;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        op_reg    <= a;
                        k_reg     <= '0;
                        state_reg <= ST_SCAN;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_reg == ST_SCAN);
    assign done = (state_reg == ST_DONE);
    assign y    = y_reg;
    assign idx  = idx_reg;

endmodule

// File: tb/tb_nor_reduce_seq.sv
// Directed bench for nor_reduce_seq in three geometries: (32,8), (10,4), (1,1).
module tb_nor_reduce_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a0 = '0;
    logic [9:0]  a1 = '0;
    logic [0:0]  a2 = '0;
    logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic        y0, y1, y2;
    logic [4:0]  idx0;
    logic [3:0]  idx1;
    logic [0:0]  idx2;

    int errors = 0;
    int checks = 0;
    int sel_g  = 0;

    logic        ob, od, oy;
    logic [31:0] oi;

    nor_reduce_seq #(.WIDTH(32), .CHUNK(8)) dut0 (
        .clk(clk), .rst(rst), .a(a0), .start(start0),
        .busy(busy0), .done(done0), .y(y0), .idx(idx0)
    );
    nor_reduce_seq #(.WIDTH(10), .CHUNK(4)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .start(start1),
        .busy(busy1), .done(done1), .y(y1), .idx(idx1)
    );
    nor_reduce_seq #(.WIDTH(1), .CHUNK(1)) dut2 (
        .clk(clk), .rst(rst), .a(a2), .start(start2),
        .busy(busy2), .done(done2), .y(y2), .idx(idx2)
    );

    always #5 clk = ~clk;

    assign ob = (sel_g == 0) ? busy0 : (sel_g == 1) ? busy1 : busy2;
    assign od = (sel_g == 0) ? done0 : (sel_g == 1) ? done1 : done2;
    assign oy = (sel_g == 0) ? y0    : (sel_g == 1) ? y1    : y2;
    assign oi = (sel_g == 0) ? {27'b0, idx0} : (sel_g == 1) ? {28'b0, idx1} : {31'b0, idx2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [31:0] av);
        case (sel_g)
            0:       begin start0 = s; a0 = av;       end
            1:       begin start1 = s; a1 = av[9:0];  end
            default: begin start2 = s; a2 = av[0:0];  end
        endcase
    endtask

    // Presents start for one edge; returns #1 into cycle 1.
    task automatic start_op(input logic [31:0] av);
        drive(1'b1, av);
        @(posedge clk);
        #1;
        drive(1'b0, av);
    endtask

    // Counts cycles from 1 until DONE, optionally pulsing START mid-scan.
    task automatic wait_done(input string tag, input int exp_lat, input logic exp_y,
                             input logic [31:0] exp_idx, input logic inj, input logic [31:0] inj_a);
        int cyc = 1;
        while (!od && cyc < 20) begin
            chk({tag, " busy"}, {31'b0, ob}, 32'd1);
            if (inj && cyc == 1) drive(1'b1, inj_a);
            @(posedge clk);
            #1;
            if (inj && cyc == 1) drive(1'b0, inj_a);
            cyc++;
        end
        chk({tag, " done"}, {31'b0, od}, 32'd1);
        chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, " y"}, {31'b0, oy}, {31'b0, exp_y});
        chk({tag, " idx"}, oi, exp_idx);
        chk({tag, " busy_in_done"}, {31'b0, ob}, 32'd0);
        $display("op %s: done at cycle %0d y=%0b idx=%0d", tag, cyc, oy, oi);
    endtask

    task automatic idle_chk(input string tag, input logic exp_y, input logic [31:0] exp_idx);
        @(posedge clk);
        #1;
        chk({tag, " idle done"}, {31'b0, od}, 32'd0);
        chk({tag, " idle busy"}, {31'b0, ob}, 32'd0);
        chk({tag, " idle y"}, {31'b0, oy}, {31'b0, exp_y});
        chk({tag, " idle idx"}, oi, exp_idx);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        sel_g = 0;
        chk("rst busy0", {31'b0, busy0}, 32'd0);
        chk("rst done0", {31'b0, done0}, 32'd0);
        chk("rst y0", {31'b0, y0}, 32'd1);
        chk("rst idx0", {27'b0, idx0}, 32'd0);
        chk("rst y1", {31'b0, y1}, 32'd1);
        chk("rst y2", {31'b0, y2}, 32'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // (32,8): start coincides with the first edge after release
        sel_g = 0;
        start_op(32'h0000_0000); wait_done("w32 zero", 5, 1'b1, 0, 1'b0, 0); idle_chk("w32 zero", 1'b1, 0);
        start_op(32'h0000_0100); wait_done("w32 0x100", 3, 1'b0, 8, 1'b0, 0); idle_chk("w32 0x100", 1'b0, 8);
        start_op(32'h8000_0001); wait_done("w32 0x80000001", 2, 1'b0, 0, 1'b0, 0); idle_chk("w32 0x80000001", 1'b0, 0);
        start_op(32'h8000_0000); wait_done("w32 msb", 5, 1'b0, 31, 1'b0, 0); idle_chk("w32 msb", 1'b0, 31);
        start_op(32'h0001_0000); wait_done("w32 bit16", 4, 1'b0, 16, 1'b0, 0); idle_chk("w32 bit16", 1'b0, 16);
        start_op(32'h0000_0030); wait_done("w32 0x30", 2, 1'b0, 4, 1'b0, 0); idle_chk("w32 0x30", 1'b0, 4);

        // START during SCAN with a different operand is ignored
        start_op(32'h4000_0000); wait_done("w32 ignore", 5, 1'b0, 30, 1'b1, 32'h0000_0001);
        idle_chk("w32 ignore", 1'b0, 30);

        // Back-to-back: START held in DONE cycle
        start_op(32'h0000_0200); wait_done("w32 b2b first", 3, 1'b0, 9, 1'b0, 0);
        start_op(32'h0080_0000); wait_done("w32 b2b second", 4, 1'b0, 23, 1'b0, 0);
        idle_chk("w32 b2b", 1'b0, 23);

        // Result holds into the following SCAN
        start_op(32'h0000_0000);
        chk("hold y in scan", {31'b0, oy}, 32'd0);
        chk("hold idx in scan", oi, 32'd23);
        wait_done("w32 zero2", 5, 1'b1, 0, 1'b0, 0); idle_chk("w32 zero2", 1'b1, 0);

        // Asynchronous reset in cycle 2 of a zero scan
        start_op(32'h0000_0100); wait_done("w32 pre-rst", 3, 1'b0, 8, 1'b0, 0); idle_chk("w32 pre-rst", 1'b0, 8);
        start_op(32'h0000_0000);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst busy", {31'b0, busy0}, 32'd0);
        chk("midrst done", {31'b0, done0}, 32'd0);
        chk("midrst y", {31'b0, y0}, 32'd1);
        chk("midrst idx", {27'b0, idx0}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("postrst no done", {31'b0, done0}, 32'd0);
            chk("postrst no busy", {31'b0, busy0}, 32'd0);
        end
        $display("reset abort: no DONE in 6 cycles after release");

        // (10,4): partial last chunk
        sel_g = 1;
        start_op(32'h200); wait_done("w10 0x200", 4, 1'b0, 9, 1'b0, 0); idle_chk("w10 0x200", 1'b0, 9);
        start_op(32'h000); wait_done("w10 zero", 4, 1'b1, 0, 1'b0, 0); idle_chk("w10 zero", 1'b1, 0);
        start_op(32'h010); wait_done("w10 0x010", 3, 1'b0, 4, 1'b0, 0); idle_chk("w10 0x010", 1'b0, 4);
        start_op(32'h3FF); wait_done("w10 0x3ff", 2, 1'b0, 0, 1'b0, 0); idle_chk("w10 0x3ff", 1'b0, 0);
        start_op(32'h300); wait_done("w10 0x300", 4, 1'b0, 8, 1'b0, 0); idle_chk("w10 0x300", 1'b0, 8);

        // (1,1): single-chunk geometry, always DONE in cycle 2
        sel_g = 2;
        start_op(32'h0); wait_done("w1 zero", 2, 1'b1, 0, 1'b0, 0); idle_chk("w1 zero", 1'b1, 0);
        start_op(32'h1); wait_done("w1 one", 2, 1'b0, 0, 1'b0, 0);
        start_op(32'h0); wait_done("w1 b2b zero", 2, 1'b1, 0, 1'b0, 0); idle_chk("w1 b2b", 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
